// File: rtl/genius_control.sv
// Moore sequencer for the Genius game datapath, with a synchronised and debounced enter button.
// Outputs are decoded from the state register only; the enter pulse comes from the filter's registered edge.
module genius_control #(
   parameter int p_key           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [p_key-1:0] KEY,
   input  logic             end_FPGA,
   input  logic             end_User,
   input  logic             end_time,
   input  logic             win,
   input  logic             match,
   output logic             R1,
   output logic             R2,
   output logic             E1,
   output logic             E2,
   output logic             E3,
   output logic             E4,
   output logic             SEL,
   output logic [2:0]       state_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_SETUP    = 3'd1,
      S_SEQUENCE = 3'd2,
      S_PLAY     = 3'd3,
      S_CHECK    = 3'd4,
      S_RESULT   = 3'd5
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_filt;
   logic          r_filt_d;
   logic [CW-1:0] r_cnt;
   logic          w_enter;
   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic          w_unused_key;

   assign w_unused_key = ^{KEY[p_key-1:2], KEY[0]};

   // The filter only follows the synced level after it has differed for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= KEY[1];
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         if (r_sync2 != r_filt) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_filt <= r_sync2;
               r_cnt  <= '0;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign w_enter = r_filt_d & ~r_filt;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:     w_next = S_SETUP;
         S_SETUP:    if (w_enter) w_next = S_SEQUENCE;
         S_SEQUENCE: if (end_FPGA) w_next = S_PLAY;
         S_PLAY: begin
            if (end_time)     w_next = S_RESULT;
            else if (w_enter) w_next = S_CHECK;
         end
         S_CHECK: begin
            if (!match)        w_next = S_RESULT;
            else if (!end_User) w_next = S_PLAY;
            else if (win)      w_next = S_RESULT;
            else               w_next = S_SEQUENCE;
         end
         S_RESULT:   if (w_enter) w_next = S_INIT;
         default:    w_next = S_INIT;
      endcase
   end

   // Illegal codes present INIT outputs for their single cycle.
   always_comb begin
      R1  = 1'b0;
      R2  = 1'b0;
      E1  = 1'b0;
      E2  = 1'b0;
      E3  = 1'b0;
      E4  = 1'b0;
      SEL = 1'b0;
      case (r_state)
         S_SETUP:    E1 = 1'b1;
         S_SEQUENCE: begin
            E2 = 1'b1;
            R2 = 1'b1;
         end
         S_PLAY:     E3 = 1'b1;
         S_CHECK:    E4 = 1'b1;
         S_RESULT:   SEL = 1'b1;
         default: begin
            R1 = 1'b1;
            R2 = 1'b1;
         end
      endcase
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_genius_control.sv
// Directed bench for genius_control with a short debounce; expected output vectors go through a scoreboard queue.
module tb_genius_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key;
   logic       end_fpga, end_user, end_time, win, match;
   logic       r1, r2, e1, e2, e3, e4, sel;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   int enter_cnt = 0;
   int cnt0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   genius_control #(.p_key(4), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
      .end_FPGA(end_fpga), .end_User(end_user), .end_time(end_time),
      .win(win), .match(match),
      .R1(r1), .R2(r2), .E1(e1), .E2(e2), .E3(e3), .E4(e4), .SEL(sel),
      .state_o(state)
   );

   always @(posedge clk) if (dut.w_enter === 1'b1) enter_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Bench's own view of the Moore decode: {state, R1, R2, E1, E2, E3, E4, SEL}.
   function automatic logic [9:0] exp_vec(input logic [2:0] s);
      case (s)
         3'd1:    exp_vec = {s, 7'b0010000};
         3'd2:    exp_vec = {s, 7'b0101000};
         3'd3:    exp_vec = {s, 7'b0000100};
         3'd4:    exp_vec = {s, 7'b0000010};
         3'd5:    exp_vec = {s, 7'b0000001};
         default: exp_vec = {s, 7'b1100000};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input logic [2:0] s, input string tag);
      logic [9:0] want;
      logic [9:0] got;
      exp_q.push_back(exp_vec(s));
      want = exp_q.pop_front();
      got  = {state, r1, r2, e1, e2, e3, e4, sel};
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, got, want);
      end
   endtask

   task automatic check_int(input int got, input int want, input string tag);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Press and hold enter until the state update caused by the pulse is visible.
   task automatic press_until_edge();
      key[1] = 1'b0;
      repeat (7) step();
   endtask

   task automatic release_key();
      key[1] = 1'b1;
      repeat (8) step();
   endtask

   initial begin
      rst_n = 1'b0; key = 4'hF;
      end_fpga = 0; end_user = 0; end_time = 0; win = 0; match = 0;
      #1;
      expect_state(3'd0, "reset_init");
      repeat (3) step();
      expect_state(3'd0, "reset_hold");
      rst_n = 1'b1;
      step();
      expect_state(3'd1, "init_to_setup");
      step();
      expect_state(3'd1, "setup_waits");

      // Short bounce must not pass the filter.
      cnt0 = enter_cnt;
      key[1] = 1'b0;
      repeat (3) step();
      key[1] = 1'b1;
      repeat (8) step();
      check_int(enter_cnt - cnt0, 0, "short_press_pulses");
      expect_state(3'd1, "short_press_stays");

      // Long press: pulse visible after six edges, transition on the seventh.
      cnt0 = enter_cnt;
      key[1] = 1'b0;
      repeat (6) step();
      expect_state(3'd1, "before_enter_edge");
      step();
      expect_state(3'd2, "setup_to_sequence");
      repeat (5) step();
      release_key();
      check_int(enter_cnt - cnt0, 1, "hold_one_pulse");
      expect_state(3'd2, "sequence_waits");

      end_fpga = 1; step(); end_fpga = 0;
      expect_state(3'd3, "sequence_to_play");
      match = 1; end_user = 0;
      press_until_edge();
      expect_state(3'd4, "play_to_check");
      step();
      expect_state(3'd3, "check_to_play");
      release_key();
      expect_state(3'd3, "play_waits");

      end_user = 1; win = 0;
      press_until_edge();
      expect_state(3'd4, "check_round");
      step();
      expect_state(3'd2, "check_next_round");
      release_key();
      end_fpga = 1; step(); end_fpga = 0;
      expect_state(3'd3, "play_round2");
      win = 1;
      press_until_edge();
      expect_state(3'd4, "check_win");
      step();
      expect_state(3'd5, "win_result");
      release_key();
      expect_state(3'd5, "result_waits");

      press_until_edge();
      expect_state(3'd0, "result_to_init");
      step();
      expect_state(3'd1, "init_to_setup2");
      release_key();

      // end_time and enter pulse in the same PLAY cycle.
      press_until_edge();
      expect_state(3'd2, "setup_to_sequence2");
      release_key();
      end_fpga = 1; step(); end_fpga = 0;
      key[1] = 1'b0;
      repeat (6) step();
      end_time = 1;
      step();
      end_time = 0;
      expect_state(3'd5, "timeout_beats_enter");
      release_key();

      press_until_edge(); step(); release_key();
      expect_state(3'd1, "back_to_setup");
      press_until_edge(); release_key();
      end_fpga = 1; step(); end_fpga = 0;
      expect_state(3'd3, "play_for_mismatch");
      match = 0; end_user = 1; win = 1;
      press_until_edge();
      expect_state(3'd4, "check_mismatch");
      step();
      expect_state(3'd5, "mismatch_result");
      release_key();

      // Asynchronous reset in the middle of PLAY.
      press_until_edge(); step(); release_key();
      press_until_edge(); release_key();
      end_fpga = 1; step(); end_fpga = 0;
      expect_state(3'd3, "play_before_reset");
      rst_n = 1'b0;
      #1;
      expect_state(3'd0, "async_reset_play");
      step();
      rst_n = 1'b1;
      step();
      expect_state(3'd1, "reset_release_setup");

      // Illegal code recovers to INIT.
      @(negedge clk);
      force dut.r_state = 3'd6;
      #1;
      expect_state(3'd6, "illegal_outputs");
      release dut.r_state;
      step();
      expect_state(3'd0, "illegal_to_init");
      step();
      expect_state(3'd1, "illegal_then_setup");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
